// File: rtl/fft_adapter_pkg.sv
// Shared types and helpers for the FFT frame adapters: FSM state, output width
// and component padding.
package fft_adapter_pkg;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StInFrame = 1'b1
  } state_e;

  // Widest padded field the helper supports; callers truncate to their width.
  localparam int unsigned MaxFieldW = 64;

  function automatic int unsigned out_width(input int unsigned s, input int unsigned l,
                                            input int unsigned r);
    return 2 * (l + s + r) + 1;
  endfunction

  // Sign-extends an s-bit component held in the low bits of comp, then appends
  // r zero bits. The L sign copies come from truncating the result to L+S+R.
  function automatic logic [MaxFieldW-1:0] pad_field(input logic [MaxFieldW-1:0] comp,
                                                     input int unsigned s,
                                                     input int unsigned r);
    logic signed [MaxFieldW-1:0] ext;
    ext = $signed(comp << (MaxFieldW - s));
    ext = ext >>> (MaxFieldW - s);
    return $unsigned(ext) << r;
  endfunction

endpackage

// File: rtl/fft_skid_buffer.sv
// Two-entry valid/ready skid buffer. Both in_ready_o and the output side are
// driven straight from flops.
module fft_skid_buffer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [Width-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [Width-1:0] skid_data_q, skid_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q;
  logic             in_fire;
  logic             out_free;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_free = ~out_valid_q | out_ready_i;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      // in_ready_q is low here, so no new beat can arrive this cycle.
      if (out_free) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (out_free) begin
        out_data_d  = in_data_i;
        out_valid_d = 1'b1;
      end else begin
        skid_data_d  = in_data_i;
        skid_valid_d = 1'b1;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/fft_frame_adapter_rx.sv
// Receive-side adapter into the FFT core: pads complex samples to FFT width, tags the
// per-frame inverse flag and enforces FFT_POINTS-sample framing.
module fft_frame_adapter_rx
  import fft_adapter_pkg::*;
#(
  parameter int unsigned INPUT_SYMBOL_WIDTH  = 12,
  parameter int unsigned EXTRA_LEFT_PADDING  = 2,
  parameter int unsigned EXTRA_RIGHT_PADDING = 2,
  parameter int unsigned FFT_POINTS          = 1024,
  parameter bit          INVERSE_FFT         = 1'b0
) (
  input  logic                            clock_clk,
  input  logic                            reset_reset,
  input  logic [2*INPUT_SYMBOL_WIDTH-1:0] asi_in_data,
  input  logic                            asi_in_valid,
  input  logic                            asi_in_startofpacket,
  input  logic                            asi_in_endofpacket,
  output logic                            asi_in_ready,
  output logic [out_width(INPUT_SYMBOL_WIDTH, EXTRA_LEFT_PADDING,
                          EXTRA_RIGHT_PADDING)-1:0] aso_out_data,
  output logic                            aso_out_valid,
  output logic                            aso_out_startofpacket,
  output logic                            aso_out_endofpacket,
  input  logic                            aso_out_ready,
  input  logic                            cfg_inverse,
  input  logic                            cfg_regen_framing,
  output logic                            stat_frame_error,
  output logic [15:0]                     stat_frame_count
);

  localparam int unsigned S      = INPUT_SYMBOL_WIDTH;
  localparam int unsigned FieldW = EXTRA_LEFT_PADDING + S + EXTRA_RIGHT_PADDING;
  localparam int unsigned OutW   = out_width(S, EXTRA_LEFT_PADDING, EXTRA_RIGHT_PADDING);
  localparam int unsigned IdxW   = $clog2(FFT_POINTS);
  localparam int unsigned BufW   = OutW + 2;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              inv_q, inv_d;
  logic              regen_q, regen_d;
  logic              discard_q, discard_d;
  logic              err_q, err_d;
  logic [15:0]       count_q;

  logic              in_fire;
  logic              idx_last;
  logic              inv_bit;
  logic              buf_valid, buf_sop, buf_eop;
  logic [FieldW-1:0] real_field, imag_field;
  logic [BufW-1:0]   buf_data, out_bundle;

  assign in_fire  = asi_in_valid & asi_in_ready;
  assign idx_last = (idx_q == IdxW'(FFT_POINTS - 1));

  assign real_field = FieldW'(pad_field(MaxFieldW'(asi_in_data[2*S-1:S]), S,
                                        EXTRA_RIGHT_PADDING));
  assign imag_field = FieldW'(pad_field(MaxFieldW'(asi_in_data[S-1:0]), S,
                                        EXTRA_RIGHT_PADDING));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    inv_d     = inv_q;
    regen_d   = regen_q;
    discard_d = discard_q;
    err_d     = 1'b0;
    buf_valid = 1'b0;
    buf_sop   = 1'b0;
    buf_eop   = 1'b0;
    inv_bit   = inv_q;
    unique case (state_q)
      StIdle: begin
        // A frame-start beat already carries the newly latched flag.
        inv_bit = cfg_inverse;
        if (in_fire) begin
          if (cfg_regen_framing || asi_in_startofpacket) begin
            inv_d     = cfg_inverse;
            regen_d   = cfg_regen_framing;
            discard_d = 1'b0;
            buf_valid = 1'b1;
            buf_sop   = 1'b1;
            idx_d     = IdxW'(1);
            state_d   = StInFrame;
            if (!cfg_regen_framing && asi_in_endofpacket) begin
              buf_eop = 1'b1;
              err_d   = 1'b1;
              idx_d   = '0;
              state_d = StIdle;
            end
          end else begin
            // Only the first beat of a discarded run is reported.
            err_d     = ~discard_q;
            discard_d = 1'b1;
          end
        end
      end
      StInFrame: begin
        if (in_fire) begin
          buf_valid = 1'b1;
          idx_d     = idx_q + IdxW'(1);
          if (regen_q) begin
            buf_eop = idx_last;
          end else begin
            buf_eop = asi_in_endofpacket | idx_last;
            err_d   = asi_in_startofpacket | (asi_in_endofpacket ^ idx_last);
          end
          if (buf_eop) begin
            idx_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      inv_q     <= INVERSE_FFT;
      regen_q   <= 1'b0;
      discard_q <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      inv_q     <= inv_d;
      regen_q   <= regen_d;
      discard_q <= discard_d;
      err_q     <= err_d;
      if (buf_valid && buf_eop) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign buf_data = {real_field, imag_field, inv_bit, buf_sop, buf_eop};

  fft_skid_buffer #(
    .Width (BufW)
  ) u_skid (
    .clk_i       (clock_clk),
    .rst_i       (reset_reset),
    .in_data_i   (buf_data),
    .in_valid_i  (buf_valid),
    .in_ready_o  (asi_in_ready),
    .out_data_o  (out_bundle),
    .out_valid_o (aso_out_valid),
    .out_ready_i (aso_out_ready)
  );

  assign {aso_out_data, aso_out_startofpacket, aso_out_endofpacket} = out_bundle;
  assign stat_frame_error = err_q;
  assign stat_frame_count = count_q;

endmodule
